fifo_pkt_ctrl: RTL



---
 rtl/fifo_pkt_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_pkt_ctrl.sv
// Packet store-and-forward controller in front of a pointer-resettable fifo_sync.
// Optional drop/overflow statistics outputs are enabled with FIFO_PKT_CTRL_STATS_EN.
module fifo_pkt_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_W     = 19,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_drop,
    output logic                  fifo_wen,
    output logic [DATA_W:0]       fifo_wdata,
    input  logic                  fifo_full,
    output logic                  fifo_wrst,
    output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
    input  logic [ADDR_WIDTH:0]   fifo_wptr,
    output logic                  fifo_ren,
    input  logic [DATA_W:0]       fifo_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_eop,
    output logic [CNT_W-1:0]      pkt_cnt
`ifdef FIFO_PKT_CTRL_STATS_EN
    ,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           ovf_cnt
`endif
);

    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DISCARD, W_ROLLBACK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_HOLD} r_state_t;

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH:0]   start_ptr_q, start_ptr_d;
    logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_eop_q, out_eop_d;
    logic                  fifo_wrst_q, fifo_wrst_d;
    logic                  accept, commit, handover_eop, rb_drop, rb_ovf;

    always_comb begin
        accept      = in_valid && in_ready;
        fifo_wen    = 1'b0;
        commit      = 1'b0;
        rb_drop     = 1'b0;
        rb_ovf      = 1'b0;
        w_state_d   = w_state_q;
        start_ptr_d = start_ptr_q;

        case (w_state_q)
            W_IDLE: begin
                if (accept && in_sop) begin
                    start_ptr_d = fifo_wptr;
                    if (fifo_full) begin
                        rb_ovf    = in_eop;
                        w_state_d = in_eop ? W_ROLLBACK : W_DISCARD;
                    end else begin
                        fifo_wen = 1'b1;
                        if (in_eop) begin
                            if (in_drop) begin
                                rb_drop   = 1'b1;
                                w_state_d = W_ROLLBACK;
                            end else begin
                                commit = 1'b1;
                            end
                        end else begin
                            w_state_d = W_PKT;
                        end
                    end
                end
            end
            W_PKT: begin
                if (accept) begin
                    // A second sop mid-packet is a framing error: drop the old packet and the new sop.
                    if (in_sop) begin
                        rb_ovf    = 1'b1;
                        w_state_d = W_ROLLBACK;
                    end else if (fifo_full) begin
                        rb_ovf    = in_eop;
                        w_state_d = in_eop ? W_ROLLBACK : W_DISCARD;
                    end else begin
                        fifo_wen = 1'b1;
                        if (in_eop) begin
                            if (in_drop) begin
                                rb_drop   = 1'b1;
                                w_state_d = W_ROLLBACK;
                            end else begin
                                commit    = 1'b1;
                                w_state_d = W_IDLE;
                            end
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (accept && in_eop) begin
                    rb_ovf    = 1'b1;
                    w_state_d = W_ROLLBACK;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        fifo_wrst_d = (w_state_d == W_ROLLBACK);
    end

    assign in_ready      = (w_state_q != W_ROLLBACK) && (pkt_cnt_q != {CNT_W{1'b1}});
    assign fifo_wdata    = {in_eop, in_data};
    assign fifo_wrst     = fifo_wrst_q;
    assign fifo_rst_wptr = start_ptr_q;

    // Reader only fetches while a fully committed packet is pending.
    assign fifo_ren     = (r_state_q == R_IDLE) && (pkt_cnt_q != '0) && !out_valid_q;
    assign handover_eop = out_valid_q && out_ready && out_eop_q;

    always_comb begin
        r_state_d   = r_state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eop_d   = out_eop_q;
        case (r_state_q)
            R_IDLE: begin
                if (fifo_ren) r_state_d = R_FETCH;
            end
            R_FETCH: begin
                out_data_d  = fifo_rdata[DATA_W-1:0];
                out_eop_d   = fifo_rdata[DATA_W];
                out_valid_d = 1'b1;
                r_state_d   = R_HOLD;
            end
            R_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    r_state_d   = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        case ({commit, handover_eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_eop   = out_eop_q;
    assign pkt_cnt   = pkt_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            start_ptr_q <= '0;
            pkt_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eop_q   <= 1'b0;
            fifo_wrst_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            start_ptr_q <= start_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eop_q   <= out_eop_d;
            fifo_wrst_q <= fifo_wrst_d;
        end
    end

`ifdef FIFO_PKT_CTRL_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (rb_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        if (rb_ovf && ovf_cnt_q != 16'hFFFF)   ovf_cnt_d  = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule
